// File: rtl/multi_gate_counter.sv
// N-channel gated pulse counter: counts synchronised rising edges on each input over a
// programmed number of whole seconds and latches the results into a byte-addressed window.
module multi_gate_counter #(
    parameter int          N_CH        = 4,
    parameter int          CNT_WIDTH   = 32,
    parameter logic [7:0]  BASE_ADDR   = 8'h40,
    parameter int          CLK_PER_SEC = 50_000_000,
    parameter int          STOP_HOLD   = 500_000
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic [7:0]                addr,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      we,
    input  logic                      start,
    input  logic                      abort,
    output logic                      ready,
    output logic                      stop,
    input  logic [N_CH-1:0]           signal,
    output logic [N_CH*CNT_WIDTH-1:0] count_ex,
    output logic [31:0]               time_ex,
    output logic [N_CH-1:0]           ovf
);

    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_ARM   = 3'd1;
    localparam logic [2:0]  S_COUNT = 3'd2;
    localparam logic [2:0]  S_LATCH = 3'd3;
    localparam logic [2:0]  S_HOLD  = 3'd4;

    localparam int          CW         = CNT_WIDTH;
    localparam logic [31:0] PRESC_LAST = 32'(CLK_PER_SEC - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(STOP_HOLD - 1);
    localparam logic [7:0]  WIN_SIZE   = 8'(8 + 4 * N_CH);

    logic [2:0]              state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    stop_q, stop_d;
    logic [7:0]              sec_left_q, sec_left_d;
    logic [31:0]             presc_q, presc_d;
    logic [31:0]             live_time_q, live_time_d;
    logic [N_CH*CW-1:0]      live_cnt_q, live_cnt_d;
    logic [N_CH-1:0]         live_ovf_q, live_ovf_d;
    logic [31:0]             hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    run_cont_q, run_cont_d;
    logic [N_CH*CW-1:0]      count_ex_q, count_ex_d;
    logic [31:0]             time_ex_q, time_ex_d;
    logic [N_CH-1:0]         ovf_q, ovf_d;

    logic                    ctrl_cont_q;
    logic [7:0]              gate_q;
    logic [7:0]              data_out_q;
    logic [N_CH-1:0]         sync1_q, sync2_q, sync3_q;

    logic [N_CH-1:0]         edge_s;
    logic [7:0]              off_s;
    logic                    in_win_s;
    logic                    sw_start_s;
    logic                    start_req_s;
    logic [7:0]              rd_s;
    logic [N_CH*32-1:0]      cnt_pad_s;

    assign edge_s      = sync2_q & ~sync3_q;
    assign off_s       = addr - BASE_ADDR;
    assign in_win_s    = (addr >= BASE_ADDR) && (off_s < WIN_SIZE);
    assign sw_start_s  = we && in_win_s && (off_s == 8'd0) && data_in[1];
    assign start_req_s = start || sw_start_s;

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign stop     = stop_q;
    assign count_ex = count_ex_q;
    assign time_ex  = time_ex_q;
    assign ovf      = ovf_q;

    // Input synchronisers plus one extra stage for rising-edge detection
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= signal;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Control register writes and registered read data
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ctrl_cont_q <= 1'b0;
            gate_q      <= 8'h00;
            data_out_q  <= 8'h00;
        end else begin
            data_out_q <= rd_s;
            if (we && in_win_s && (off_s == 8'd0)) begin
                ctrl_cont_q <= data_in[0];
            end
            if (we && in_win_s && (off_s == 8'd1)) begin
                gate_q <= data_in;
            end
        end
    end

    // Zero-extend latched counts to 32 bits per channel so the byte mux is width-independent
    always_comb begin
        cnt_pad_s = '0;
        for (int c = 0; c < N_CH; c++) begin
            cnt_pad_s[c*32 +: 32] = 32'(count_ex_q[c*CW +: CW]);
        end
    end

    // Read multiplexer; bytes above the counter width come out as zero via the padding
    always_comb begin
        rd_s = 8'h00;
        if (in_win_s) begin
            case (off_s)
                8'd0:    rd_s = {7'b0, ctrl_cont_q};
                8'd1:    rd_s = gate_q;
                8'd2:    rd_s = {4'b0, aborted_q, done_q, (state_q != S_IDLE), ready_q};
                8'd3:    rd_s = 8'h00;
                8'd4:    rd_s = time_ex_q[7:0];
                8'd5:    rd_s = time_ex_q[15:8];
                8'd6:    rd_s = time_ex_q[23:16];
                8'd7:    rd_s = time_ex_q[31:24];
                default: begin
                    for (int c = 0; c < N_CH; c++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (off_s == 8'(8 + 4 * c + b)) begin
                                rd_s = cnt_pad_s[c*32 + 8*b +: 8];
                            end else begin
                                rd_s = rd_s;
                            end
                        end
                    end
                end
            endcase
        end else begin
            rd_s = 8'h00;
        end
    end

    // Gate sequencer next-state logic
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        stop_d      = stop_q;
        sec_left_d  = sec_left_q;
        presc_d     = presc_q;
        live_time_d = live_time_q;
        live_cnt_d  = live_cnt_q;
        live_ovf_d  = live_ovf_q;
        hold_d      = hold_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        run_cont_d  = run_cont_q;
        count_ex_d  = count_ex_q;
        time_ex_d   = time_ex_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (start_req_s) begin
                    state_d = S_ARM;
                    ready_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                live_cnt_d  = '0;
                live_ovf_d  = '0;
                live_time_d = 32'd0;
                presc_d     = 32'd0;
                sec_left_d  = gate_q;
                done_d      = 1'b0;
                aborted_d   = 1'b0;
                run_cont_d  = ctrl_cont_q;
                if (gate_q == 8'd0) begin
                    state_d = S_LATCH;
                end else begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                live_time_d = live_time_q + 32'd1;
                for (int c = 0; c < N_CH; c++) begin
                    if (edge_s[c]) begin
                        if (live_cnt_q[c*CW +: CW] == {CW{1'b1}}) begin
                            live_ovf_d[c] = 1'b1;
                        end else begin
                            live_cnt_d[c*CW +: CW] = live_cnt_q[c*CW +: CW] + CW'(1);
                        end
                    end else begin
                        live_ovf_d[c] = live_ovf_q[c];
                    end
                end
                if (presc_q == PRESC_LAST) begin
                    presc_d    = 32'd0;
                    sec_left_d = sec_left_q - 8'd1;
                    if (sec_left_q == 8'd1) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_COUNT;
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
                // Abort wins over a normal gate end in the same cycle so the flag is never lost
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_LATCH;
                end else begin
                    aborted_d = aborted_q;
                end
            end
            S_LATCH: begin
                count_ex_d = live_cnt_q;
                time_ex_d  = live_time_q;
                ovf_d      = live_ovf_q;
                done_d     = 1'b1;
                stop_d     = 1'b1;
                hold_d     = 32'd0;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    stop_d = 1'b0;
                    hold_d = 32'd0;
                    if (run_cont_q && !aborted_q && !abort) begin
                        state_d = S_ARM;
                    end else begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                stop_d  = 1'b0;
            end
        endcase
    end

    // Gate sequencer state registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            stop_q      <= 1'b0;
            sec_left_q  <= 8'd0;
            presc_q     <= 32'd0;
            live_time_q <= 32'd0;
            live_cnt_q  <= '0;
            live_ovf_q  <= '0;
            hold_q      <= 32'd0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            run_cont_q  <= 1'b0;
            count_ex_q  <= '0;
            time_ex_q   <= 32'd0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            stop_q      <= stop_d;
            sec_left_q  <= sec_left_d;
            presc_q     <= presc_d;
            live_time_q <= live_time_d;
            live_cnt_q  <= live_cnt_d;
            live_ovf_q  <= live_ovf_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            run_cont_q  <= run_cont_d;
            count_ex_q  <= count_ex_d;
            time_ex_q   <= time_ex_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_multi_gate_counter.sv
// Directed bench for multi_gate_counter: a 32-bit and an 8-bit instance share all inputs,
// with CLK_PER_SEC=100 and STOP_HOLD=10 so gates are short.
module tb_multi_gate_counter;

    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             res_n = 1'b0;
    logic [7:0]       addr = 8'h00;
    logic [7:0]       data_in = 8'h00;
    logic             we = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NCH-1:0]   signal = '0;

    logic [7:0]       dout_a, dout_b;
    logic             ready_a, ready_b, stop_a, stop_b;
    logic [NCH*32-1:0] cnt_a;
    logic [NCH*8-1:0]  cnt_b;
    logic [31:0]      time_a, time_b;
    logic [NCH-1:0]   ovf_a, ovf_b;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    multi_gate_counter #(.N_CH(NCH), .CNT_WIDTH(32), .BASE_ADDR(8'h40),
                         .CLK_PER_SEC(100), .STOP_HOLD(10)) dut_a (
        .clk(clk), .res_n(res_n), .addr(addr), .data_in(data_in), .data_out(dout_a),
        .we(we), .start(start), .abort(abort), .ready(ready_a), .stop(stop_a),
        .signal(signal), .count_ex(cnt_a), .time_ex(time_a), .ovf(ovf_a));

    multi_gate_counter #(.N_CH(NCH), .CNT_WIDTH(8), .BASE_ADDR(8'h40),
                         .CLK_PER_SEC(100), .STOP_HOLD(10)) dut_b (
        .clk(clk), .res_n(res_n), .addr(addr), .data_in(data_in), .data_out(dout_b),
        .we(we), .start(start), .abort(abort), .ready(ready_b), .stop(stop_b),
        .signal(signal), .count_ex(cnt_b), .time_ex(time_b), .ovf(ovf_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; we = 1'b1;
        cyc(1);
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        cyc(1);
        d = dout_a;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulses(input int ch, input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            signal[ch] = 1'b1;
            cyc(hi);
            signal[ch] = 1'b0;
            cyc(lo);
        end
    endtask

    task automatic wait_stop(input logic want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (stop_a === want) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ready_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        res_n = 1'b0;
        cyc(3);
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_a); end
        checks++; if (stop_a !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b want 0", stop_a); end
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout_a); end
        checks++; if (cnt_a !== '0 || time_a !== 32'd0 || ovf_a !== '0) begin
            errors++; $display("FAIL reset_results: cnt=%h time=%0d ovf=%b want all 0", cnt_a, time_a, ovf_a); end
        res_n = 1'b1;
        cyc(1);
        rd(8'h40, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", d); end
        rd(8'h41, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_gate: got %h want 00", d); end
        rd(8'h42, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL reset_status: got %h want 01", d); end
    endtask

    task automatic test_basic_gate();
        logic [7:0] d;
        bit ok;
        int n;
        wr(8'h40, 8'h00);
        wr(8'h41, 8'd3);
        pulse_start();
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got %b want 0", ready_a); end
        pulses(0, 25, 2, 2);
        wait_stop(1'b1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_stop_rise: got timeout want stop=1"); end
        n = 0;
        while (stop_a === 1'b1 && n < 50) begin
            n++;
            cyc(1);
        end
        checks++; if (n != 10) begin errors++; $display("FAIL basic_stop_len: got %0d want 10", n); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", ready_a); end
        checks++; if (cnt_a[31:0] !== 32'd25) begin errors++; $display("FAIL basic_cnt0: got %0d want 25", cnt_a[31:0]); end
        checks++; if (cnt_a[63:32] !== 32'd0) begin errors++; $display("FAIL basic_cnt1: got %0d want 0", cnt_a[63:32]); end
        checks++; if (time_a !== 32'd300) begin errors++; $display("FAIL basic_time: got %0d want 300", time_a); end
        checks++; if (ovf_a !== 4'b0000) begin errors++; $display("FAIL basic_ovf: got %b want 0000", ovf_a); end
        rd(8'h42, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL basic_status: got %h want 05", d); end
        rd(8'h48, d);
        checks++; if (d !== 8'd25) begin errors++; $display("FAIL basic_rd_cnt0: got %h want 19", d); end
        rd(8'h44, d);
        checks++; if (d !== 8'h2C) begin errors++; $display("FAIL basic_rd_time0: got %h want 2c", d); end
        rd(8'h45, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL basic_rd_time1: got %h want 01", d); end
        rd(8'h43, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL basic_rd_unmapped: got %h want 00", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        bit ok;
        wr(8'h41, 8'd7);
        pulse_start();
        pulses(2, 300, 1, 1);
        wait_stop(1'b1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_stop_rise: got timeout want stop=1"); end
        checks++; if (cnt_b[23:16] !== 8'd255) begin errors++; $display("FAIL ovf_cnt8: got %0d want 255", cnt_b[23:16]); end
        checks++; if (ovf_b !== 4'b0100) begin errors++; $display("FAIL ovf_flags8: got %b want 0100", ovf_b); end
        checks++; if (cnt_a[95:64] !== 32'd300) begin errors++; $display("FAIL ovf_cnt32: got %0d want 300", cnt_a[95:64]); end
        checks++; if (ovf_a !== 4'b0000) begin errors++; $display("FAIL ovf_flags32: got %b want 0000", ovf_a); end
        wait_ready(50, ok);
        addr = 8'h49;
        cyc(1);
        checks++; if (dout_b !== 8'h00) begin errors++; $display("FAIL ovf_rd_above_width: got %h want 00", dout_b); end
        rd(8'h50, d);
        checks++; if (d !== 8'h2C) begin errors++; $display("FAIL ovf_rd_cnt2: got %h want 2c", d); end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        bit ok;
        wr(8'h40, 8'h01);
        wr(8'h41, 8'd4);
        pulse_start();
        pulses(1, 5, 2, 2);
        cyc(130);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        wait_stop(1'b1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_stop_rise: got timeout want stop=1"); end
        checks++; if (time_a !== 32'd150 && time_a !== 32'd151) begin
            errors++; $display("FAIL abort_time: got %0d want 150 or 151", time_a); end
        checks++; if (cnt_a[63:32] !== 32'd5) begin errors++; $display("FAIL abort_partial: got %0d want 5", cnt_a[63:32]); end
        wait_stop(1'b0, 20, ok);
        cyc(20);
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL abort_no_restart: got ready=%b want 1", ready_a); end
        rd(8'h42, d);
        checks++; if (d !== 8'h0D) begin errors++; $display("FAIL abort_status: got %h want 0d", d); end
        wr(8'h40, 8'h00);
    endtask

    task automatic test_gate_zero();
        logic [7:0] d;
        bit ok;
        wr(8'h41, 8'd0);
        wr(8'h40, 8'h02);
        cyc(2);
        checks++; if (stop_a !== 1'b1) begin errors++; $display("FAIL g0_stop: got %b want 1", stop_a); end
        checks++; if (cnt_a !== '0 || time_a !== 32'd0) begin
            errors++; $display("FAIL g0_zero: cnt=%h time=%0d want 0", cnt_a, time_a); end
        rd(8'h49, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL g0_rd: got %h want 00", d); end
        rd(8'h42, d);
        checks++; if (d !== 8'h06) begin errors++; $display("FAIL g0_status: got %h want 06", d); end
        wait_ready(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL g0_ready: got timeout want ready=1"); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bit ok;
        int t1, t2;
        wr(8'h40, 8'h01);
        wr(8'h41, 8'd1);
        pulse_start();
        pulses(0, 10, 2, 2);
        wait_stop(1'b1, 200, ok);
        t1 = cyc_cnt;
        checks++; if (cnt_a[31:0] !== 32'd10) begin errors++; $display("FAIL b2b_cnt_g1: got %0d want 10", cnt_a[31:0]); end
        wait_stop(1'b0, 50, ok);
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", ready_a); end
        pulses(0, 10, 2, 2);
        rd(8'h48, d);
        checks++; if (d !== 8'd10) begin errors++; $display("FAIL b2b_shadow: got %0d want 10", d); end
        wr(8'h40, 8'h00);
        wait_stop(1'b1, 200, ok);
        t2 = cyc_cnt;
        checks++; if (t2 - t1 != 112) begin errors++; $display("FAIL b2b_period: got %0d want 112", t2 - t1); end
        checks++; if (cnt_a[31:0] !== 32'd10) begin errors++; $display("FAIL b2b_cnt_g2: got %0d want 10", cnt_a[31:0]); end
        cyc(2);
        wait_ready(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_final_ready: got timeout want ready=1"); end
        checks++; if (cnt_a[31:0] !== 32'd0 || time_a !== 32'd100) begin
            errors++; $display("FAIL b2b_gate3: cnt=%0d time=%0d want 0 and 100", cnt_a[31:0], time_a); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        bit ok;
        wr(8'h41, 8'd3);
        pulse_start();
        pulses(0, 5, 2, 2);
        cyc(30);
        res_n = 1'b0;
        #2;
        checks++; if (ready_a !== 1'b1 || stop_a !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags: ready=%b stop=%b want 1 0", ready_a, stop_a); end
        checks++; if (time_a !== 32'd0 || ovf_a !== '0 || cnt_a !== '0) begin
            errors++; $display("FAIL rst_mid_results: cnt=%h time=%0d ovf=%b want 0", cnt_a, time_a, ovf_a); end
        cyc(2);
        res_n = 1'b1;
        cyc(1);
        rd(8'h41, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_gate: got %h want 00", d); end
        wr(8'h41, 8'd1);
        pulse_start();
        pulses(0, 7, 2, 2);
        wait_ready(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_rerun: got timeout want ready=1"); end
        checks++; if (cnt_a[31:0] !== 32'd7 || time_a !== 32'd100) begin
            errors++; $display("FAIL rst_mid_rerun_vals: cnt=%0d time=%0d want 7 and 100", cnt_a[31:0], time_a); end
    endtask

    initial begin
        test_reset();
        test_basic_gate();
        test_overflow();
        test_abort();
        test_gate_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
